// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with wrap or saturate, terminal-count pulse and sticky overflow.
// Optional snapshot register enabled by defining MOD_COUNTER_SNAPSHOT_EN.
module mod_counter #(
    parameter int Size     = 8,
    parameter int Modulus  = 256,
    parameter int Saturate = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            up,
    input  logic            load,
    input  logic [Size-1:0] load_value,
    input  logic            clear_overflow,
    output logic [Size-1:0] count,
    output logic            tc,
`ifdef MOD_COUNTER_SNAPSHOT_EN
    output logic            overflow,
    input  logic            snapshot,
    output logic [Size-1:0] snap_count
`else
    output logic            overflow
`endif
);
    // Bound compared in Size+1 bits so Modulus == 2**Size needs no special case
    localparam logic [Size:0]   LAST_WIDE = (Size+1)'(Modulus - 1);
    localparam logic [Size-1:0] LAST      = Size'(Modulus - 1);

    logic            at_top;
    logic            at_bot;
    logic            boundary;
    logic [Size-1:0] clamped;
    logic [Size-1:0] next_count;
    logic            next_overflow;

    always_comb begin
        at_top        = {1'b0, count} == LAST_WIDE;
        at_bot        = count == '0;
        boundary      = !load && enable && (up ? at_top : at_bot);
        clamped       = ({1'b0, load_value} > LAST_WIDE) ? LAST : load_value;
        next_count    = load      ? clamped :
                        !enable   ? count :
                        boundary  ? ((Saturate != 0) ? count : (up ? '0 : LAST)) :
                        up        ? count + Size'(1) : count - Size'(1);
        next_overflow = boundary || (overflow && !clear_overflow);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            tc       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count    <= next_count;
            tc       <= boundary;
            overflow <= next_overflow;
        end
    end

`ifdef MOD_COUNTER_SNAPSHOT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            snap_count <= '0;
        else if (snapshot)
            snap_count <= count;
    end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: checks wrap, saturate and full-range counters against constant vectors and an arithmetic model.
module tb_mod_counter;
    logic clock = 1'b0;
    logic reset, enable, up, load, clear_overflow;
    logic [7:0] lv;
    logic [3:0] cnt_a, cnt_s;
    logic [7:0] cnt_b;
    logic tc_a, tc_s, tc_b, ov_a, ov_s, ov_b;
`ifdef MOD_COUNTER_SNAPSHOT_EN
    logic snapshot;
    logic [3:0] snap_a, snap_s;
    logic [7:0] snap_b;
`endif

    always #5 clock = ~clock;

    mod_counter #(.Size(4), .Modulus(10), .Saturate(0)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv[3:0]), .clear_overflow(clear_overflow),
        .count(cnt_a), .tc(tc_a),
`ifdef MOD_COUNTER_SNAPSHOT_EN
        .snapshot(snapshot), .snap_count(snap_a),
`endif
        .overflow(ov_a));
    mod_counter #(.Size(4), .Modulus(10), .Saturate(1)) dut_s (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv[3:0]), .clear_overflow(clear_overflow),
        .count(cnt_s), .tc(tc_s),
`ifdef MOD_COUNTER_SNAPSHOT_EN
        .snapshot(snapshot), .snap_count(snap_s),
`endif
        .overflow(ov_s));
    mod_counter #(.Size(8), .Modulus(256), .Saturate(0)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv), .clear_overflow(clear_overflow),
        .count(cnt_b), .tc(tc_b),
`ifdef MOD_COUNTER_SNAPSHOT_EN
        .snapshot(snapshot), .snap_count(snap_b),
`endif
        .overflow(ov_b));

    int passed = 0;
    int total  = 0;
    int mods[3]  = '{10, 10, 256};
    int sats[3]  = '{0, 1, 0};
    int masks[3] = '{15, 15, 255};
    int m_cnt[3], m_tc[3], m_ov[3], m_snap[3];

    typedef struct {
        bit en, up, ld;
        int lv;
        bit clr;
        int cnt, tc, ov;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int act_cnt(int i);
        return i == 0 ? int'(cnt_a) : i == 1 ? int'(cnt_s) : int'(cnt_b);
    endfunction
    function automatic int act_tc(int i);
        return i == 0 ? int'(tc_a) : i == 1 ? int'(tc_s) : int'(tc_b);
    endfunction
    function automatic int act_ov(int i);
        return i == 0 ? int'(ov_a) : i == 1 ? int'(ov_s) : int'(ov_b);
    endfunction
`ifdef MOD_COUNTER_SNAPSHOT_EN
    function automatic int act_snap(int i);
        return i == 0 ? int'(snap_a) : i == 1 ? int'(snap_s) : int'(snap_b);
    endfunction
`endif

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_tc[i] = 0; m_ov[i] = 0; m_snap[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int v, n;
            bit hit;
            v = int'(lv) & masks[i];
            hit = 0;
`ifdef MOD_COUNTER_SNAPSHOT_EN
            if (snapshot) m_snap[i] = m_cnt[i];
`endif
            if (load) m_cnt[i] = (v >= mods[i]) ? mods[i] - 1 : v;
            else if (enable) begin
                n = m_cnt[i] + (up ? 1 : -1);
                hit = (n < 0) || (n >= mods[i]);
                if (hit) n = sats[i] ? m_cnt[i] : (n + mods[i]) % mods[i];
                m_cnt[i] = n;
            end
            m_tc[i] = int'(hit);
            m_ov[i] = int'(hit || (m_ov[i] != 0 && !clear_overflow));
        end
    endtask

    task automatic compare_all(string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.count[%0d]", tag, i), act_cnt(i), m_cnt[i]);
            chk($sformatf("%s.tc[%0d]", tag, i), act_tc(i), m_tc[i]);
            chk($sformatf("%s.overflow[%0d]", tag, i), act_ov(i), m_ov[i]);
`ifdef MOD_COUNTER_SNAPSHOT_EN
            chk($sformatf("%s.snap[%0d]", tag, i), act_snap(i), m_snap[i]);
`endif
        end
    endtask

    task automatic tick(string tag);
        @(posedge clock);
        if (!reset) model_step();
        @(negedge clock);
        compare_all(tag);
    endtask

    task automatic drive(bit e, bit u, bit l, int v, bit c);
        enable = e; up = u; load = l; lv = 8'(v); clear_overflow = c;
    endtask

    task automatic add(bit e, bit u, bit l, int v, bit c, int cn, int t, int o);
        vec_t r;
        r.en = e; r.up = u; r.ld = l; r.lv = v; r.clr = c; r.cnt = cn; r.tc = t; r.ov = o;
        vecs.push_back(r);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1, 0, 0, 0);
`ifdef MOD_COUNTER_SNAPSHOT_EN
        snapshot = 1'b0;
`endif
        model_reset();
        #3;
        compare_all("reset");
        @(negedge clock);
        reset = 1'b0;

        // wrap up through 9 -> 0, then clamped load, count down through 0 -> 9, then clear vs wrap
        for (int k = 1; k <= 12; k++) add(1, 1, 0, 0, 0, k % 10, int'(k == 10), int'(k >= 10));
        add(0, 1, 1, 13, 0, 9, 0, 1);
        for (int k = 8; k >= 0; k--) add(1, 0, 0, 0, 0, k, 0, 1);
        add(1, 0, 0, 0, 0, 9, 1, 1);
        add(1, 1, 0, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1, 0, 0, 0);
        foreach (vecs[j]) begin
            drive(vecs[j].en, vecs[j].up, vecs[j].ld, vecs[j].lv, vecs[j].clr);
            tick("vec");
            chk($sformatf("vec%0d.count", j), int'(cnt_a), vecs[j].cnt);
            chk($sformatf("vec%0d.tc", j), int'(tc_a), vecs[j].tc);
            chk($sformatf("vec%0d.overflow", j), int'(ov_a), vecs[j].ov);
        end

        // saturating instance held at its upper bound
        drive(0, 1, 1, 9, 1);
        tick("sat_load");
        drive(1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick("sat");
            chk("sat.count", int'(cnt_s), 9);
            chk("sat.tc", int'(tc_s), 1);
            chk("sat.overflow", int'(ov_s), 1);
        end

        // full-range wrap, then asynchronous reset between edges
        drive(0, 1, 1, 255, 1);
        tick("full_load");
        drive(1, 1, 0, 0, 0);
        tick("full_wrap");
        chk("full.count", int'(cnt_b), 0);
        chk("full.tc", int'(tc_b), 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async.count", int'(cnt_b), 0);
        chk("async.tc", int'(tc_b), 0);
        chk("async.overflow", int'(ov_b), 0);
        drive(1, 1, 1, 5, 0);
        tick("reset_held");
        chk("held.count", int'(cnt_b), 0);
        reset = 1'b0;
        drive(0, 1, 0, 0, 0);
        tick("release");
        chk("release.tc", int'(tc_b), 0);
        drive(1, 1, 0, 0, 0);
        tick("first_step");
        chk("first_step.count", int'(cnt_b), 1);

`ifdef MOD_COUNTER_SNAPSHOT_EN
        drive(0, 1, 1, 5, 0);
        tick("snap_load");
        drive(1, 1, 0, 0, 0);
        snapshot = 1'b1;
        tick("snap");
        snapshot = 1'b0;
        chk("snap.snap_count", int'(snap_a), 5);
        chk("snap.count", int'(cnt_a), 6);
`endif

        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
`ifdef MOD_COUNTER_SNAPSHOT_EN
            snapshot = $urandom_range(0, 3) == 0;
`endif
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL expose the following parameters:
- Size, 8, counter width in bits.
- Modulus, 256, count range 0..Modulus-1; legal values 2..2**Size.
- Saturate, 0, boundary mode: 0 = wrap, 1 = hold at the bound.

REQ-002 The block SHALL expose the following ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  advance the count by one step this cycle.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load of load_value.
- load_value  in  Size  value to load.
- clear_overflow  in  1  clears the sticky overflow flag.
- count  out  Size  registered counter value.
- tc  out  1  registered one-cycle terminal-count pulse.
- overflow  out  1  sticky flag; set on any boundary crossing or saturation hit.

REQ-003 The design SHALL use one clock; reset is asynchronous and active-high, named clock and reset.

Function
REQ-004 The counter SHALL apply this per-cycle priority: load, then enable, then hold.
REQ-005 On load, count SHALL take load_value, clamped to Modulus-1 when load_value >= Modulus.
REQ-006 On load, tc SHALL be 0 and overflow SHALL be unchanged (apart from clear_overflow).
REQ-007 With enable=1, up=1 and count < Modulus-1, count SHALL become count+1; with up=0 and count > 0, count SHALL become count-1.
REQ-008 With enable=1, up=1 and count == Modulus-1, count SHALL become 0 when Saturate=0 and SHALL hold when Saturate=1.
REQ-009 With enable=1, up=0 and count == 0, count SHALL become Modulus-1 when Saturate=0 and SHALL hold when Saturate=1.
REQ-010 tc SHALL be 1 in the cycle after each boundary event (REQ-008/009) and 0 otherwise; it SHALL re-pulse on every further enabled cycle at the bound.
REQ-011 overflow SHALL set on each boundary event, clear when clear_overflow=1, and stay set if both occur in the same cycle.
REQ-012 Arithmetic SHALL use Size+1 bits internally so that Modulus == 2**Size wraps correctly with no truncation error.
REQ-013 A change on up SHALL take effect on the same edge it is sampled; there SHALL be no direction-change latency.
REQ-014 All outputs SHALL be registered; the latency from any input to any output SHALL be one clock.

Reset
REQ-015 While reset=1, count, tc and overflow SHALL be 0 immediately, independent of clock.
REQ-016 Reset asserted mid-operation SHALL abandon any pending load or step, and tc SHALL not pulse on reset release.
REQ-017 The first posedge after reset deassertion SHALL be processed normally.

Configuration
REQ-018 When macro MOD_COUNTER_SNAPSHOT_EN is defined, the block SHALL add ports snapshot (in, 1) and snap_count (out, Size).
REQ-019 With MOD_COUNTER_SNAPSHOT_EN defined, snap_count SHALL capture the pre-update count on each posedge where snapshot=1, and SHALL reset to 0.
REQ-020 When MOD_COUNTER_SNAPSHOT_EN is undefined, those ports and registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-021 Size=4, Modulus=10, Saturate=0, up=1, enable=1 for 12 cycles from reset -> count 1..9, 0, 1, 2; tc high exactly one cycle after count 9->0; overflow=1.
REQ-022 Same configuration, load=1 with load_value=13 -> count=9 the next cycle; then up=0 stepping down to 0 and one more step -> count=9, tc pulses.
REQ-023 Saturate=1, Modulus=10, count=9, up=1, enable=1 for 3 cycles -> count stays 9; tc high in each of those cycles; overflow=1.
REQ-024 overflow=1 with clear_overflow=1 in the same cycle as a wrap -> overflow stays 1; clear_overflow=1 alone on the next cycle -> overflow=0.
REQ-025 Size=8, Modulus=256, count=255, up=1, enable=1 -> count=0 and tc=1; reset asserted between edges -> count, tc and overflow are 0 before the next edge.
REQ-026 With MOD_COUNTER_SNAPSHOT_EN defined, count=5, snapshot=1, enable=1 -> snap_count=5 and count=6 after the edge.
